// File: rtl/sevenseg_scan_driver.sv
// rtl/sevenseg_scan_driver.sv - time-multiplexed common-anode seven-segment hex scan driver
//
// Ports:
//   clk     - system clock, all logic on rising edge
//   rst     - synchronous active-high reset
//   enable  - 1 = scan digits, 0 = display dark and scan parked at digit 0
//   load    - capture value/dp_in/lz_en into the shadow registers
//   value   - packed hex nibbles, digit 0 in the low nibble (rightmost)
//   dp_in   - per-digit decimal point request, 1 = lit
//   lz_en   - 1 = blank leading zero digits (digit 0 is never blanked)
//   seg     - {a,b,c,d,e,f,g}, active-low
//   dp      - decimal point, active-low
//   an      - digit anodes, active-low, at most one low at a time
module sevenseg_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_MAX    = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int PW = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] PCNT_LAST = PW'(DIV_MAX - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] val_q;
    logic [NUM_DIGITS-1:0]   dp_q;
    logic                    lz_q;

    logic [PW-1:0] pcnt;
    logic [IW-1:0] idx;
    logic          tick;

    logic          upper_nz;
    logic          blanked;
    logic [3:0]    cur_nib;

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'b0000001;
            4'h1: g = 7'b1001111;
            4'h2: g = 7'b0010010;
            4'h3: g = 7'b0000110;
            4'h4: g = 7'b1001100;
            4'h5: g = 7'b0100100;
            4'h6: g = 7'b0100000;
            4'h7: g = 7'b0001111;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0001100;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b1100000;
            4'hC: g = 7'b0110001;
            4'hD: g = 7'b1000010;
            4'hE: g = 7'b0110000;
            default: g = 7'b0111000;
        endcase
        return g;
    endfunction

    assign tick = (pcnt == PCNT_LAST);

    // A digit is a leading zero when it and every more-significant nibble
    // are zero; the OR-reduction covers nibbles idx..NUM_DIGITS-1.
    always_comb begin
        upper_nz = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((IW'(i) >= idx) && (val_q[4*i +: 4] != 4'd0)) begin
                upper_nz = 1'b1;
            end
        end
        cur_nib = val_q[4*idx +: 4];
        blanked = lz_q && (idx != '0) && !upper_nz;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= '0;
            dp_q  <= '0;
            lz_q  <= 1'b0;
            pcnt  <= '0;
            idx   <= '0;
            seg   <= 7'b1111111;
            dp    <= 1'b1;
            an    <= '1;
        end else begin
            // Shadows load independently of scanning so the datapath can
            // update the display while it is dark.
            if (load) begin
                val_q <= value;
                dp_q  <= dp_in;
                lz_q  <= lz_en;
            end

            if (enable) begin
                if (tick) begin
                    pcnt <= '0;
                    idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end else begin
                    pcnt <= pcnt + 1'b1;
                end
                // Pins follow the pre-edge idx/shadow state, so anode and
                // segment data always change together on the same edge.
                an  <= ~(NUM_DIGITS'(1) << idx);
                seg <= blanked ? 7'b1111111 : glyph(cur_nib);
                dp  <= ~dp_q[idx];
            end else begin
                pcnt <= '0;
                idx  <= '0;
                an   <= '1;
                seg  <= 7'b1111111;
                dp   <= 1'b1;
            end
        end
    end

endmodule
